led_blink_arbiter: RTL
======================

Name: led_blink_arbiter

Overview:
Arbitrates one shared LED blinker among N_REQ requesters and drives the blinker's enable/sel0/sel1 controls.
- Each requester asks for a blink rate.
- The winner gets the LED for a fixed hold window, followed by a mandatory dark gap.
- Grants are round-robin across requesters.
- Sits between software/status sources and the 25 kHz-clocked LED blinker.

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 25000, clk cycles LED stays enabled per grant (1 s at 25 kHz); must be >= 1
GAP_CYCLES, 1250, clk cycles of dark gap after each grant; 0 allowed
CNT_W, 16, width of the internal hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  N_REQ  level request, one bit per requester
rate  input  2*N_REQ  2-bit rate code per requester, bits [2i+1:2i]; code {sel0,sel1}: 00=1Hz, 01=10Hz, 10=50Hz, 11=100Hz
grant  output  N_REQ  one-hot current owner, all-zero when none
done  output  N_REQ  one-cycle pulse to the owner on normal hold completion
led_enable  output  1  to blinker enable
led_sel0  output  1  to blinker sel0
led_sel1  output  1  to blinker sel1
busy  output  1  high in HOLD or GAP

Behaviour:
- Reset: all outputs registered. grant=0, done=0, led_enable=0, led_sel0=0, led_sel1=0, busy=0, state=IDLE, counter=0. Round-robin pointer = requester 0 highest priority.
- Reset mid-operation: the next edge forces all reset values. No done pulse is issued.
- FSM states: IDLE, HOLD, GAP.
- IDLE, no req: remain IDLE.
- IDLE, any req: at the next edge, select the first asserted req starting from index ptr and wrapping mod N_REQ. On that edge:
  - grant[w]=1, led_enable=1.
  - {led_sel0,led_sel1} = rate[w] sampled on this edge.
  - counter=0, ptr=(w+1) mod N_REQ, state=HOLD.
  - Latency: req sampled at edge E gives led_enable=1 from E onward.
- HOLD: counter increments every edge. rate changes are ignored; the rate is latched at grant.
  - Normal end, when counter==HOLD_CYCLES-1 at an edge: grant=0, led_enable=0, done[w]=1 for exactly one cycle, counter=0. Next state is GAP, or IDLE if GAP_CYCLES==0.
  - led_enable is therefore high for exactly HOLD_CYCLES cycles.
  - Early release: if req[w]==0 sampled at an edge in HOLD, the same actions apply except done stays 0. Early release takes precedence if it coincides with the final count.
- GAP: led_enable=0, grant=0. counter increments; when counter==GAP_CYCLES-1, state=IDLE.
  - Back-to-back grants therefore have led_enable low for GAP_CYCLES+1 cycles (the IDLE arbitration cycle is included).
- led_sel0/led_sel1 keep their last value when led_enable=0 (don't-care to the blinker).
- Requests arriving during HOLD/GAP wait; req is level-sensitive and is not latched.
- Single requester holding req continuously: repeated grants separated by the gap.
- busy = (state != IDLE), registered with state.

Optional Feature:
LED_ARB_PRIO_EN
- Defined: requester 0 is urgent.
  - If req[0]=1 is sampled in HOLD (owner != 0) or in GAP, the current grant aborts at that edge with no done pulse.
  - On the same edge grant=1<<0, rate[0] is latched, counter=0, state=HOLD. The gap is skipped.
  - ptr is not updated by a preemptive grant.
  - In IDLE, requester 0 wins regardless of ptr.
- Undefined: pure round-robin, no preemption. Behaviour as above.

Test Plan (HOLD_CYCLES=8, GAP_CYCLES=2, N_REQ=4):
1. reset=1 for 3 cycles with req=4'b1111 -> all outputs 0 throughout; after reset drops, first grant=4'b0001 on the next edge.
2. req=4'b0100, rate[5:4]=2'b10 held -> grant=4'b0100, led_enable=1 for exactly 8 cycles, sel0=1 sel1=0; done=4'b0100 for 1 cycle at the 8th edge; led_enable low 3 cycles; then re-grant to requester 2.
3. req=4'b1011 held continuously -> grant sequence 0001, 0010, 1000, 0001; each hold 8 cycles, done pulsed to each owner.
4. Requester 1 granted, req[1] dropped after 3 enabled cycles -> led_enable falls at the next edge, done stays 0, GAP of 2 cycles, then IDLE.
5. rate[1:0] changed 00->11 mid-hold of requester 0 -> sel stays 00 until hold ends; the new code 11 applies on the next grant.
6. LED_ARB_PRIO_EN defined: requester 3 holding, req[0] raised at its cycle 4 -> grant switches to 4'b0001 on the next edge, no done to requester 3, led_enable stays 1, new 8-cycle hold starts. Without the macro: requester 3 completes all 8 cycles.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED blinker among N_REQ requesters. Each grant gets a fixed hold
// window followed by a dark gap. Define LED_ARB_PRIO_EN to make requester 0 urgent and preemptive.
module led_blink_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 25000,
  parameter int unsigned GAP_CYCLES  = 1250,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   rate,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 led_enable,
  output logic                 led_sel0,
  output logic                 led_sel1,
  output logic                 busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  // Wraps when GAP_CYCLES is 0, but GAP is never entered in that configuration.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               en_q, en_d;
  logic [1:0]         sel_q, sel_d;  // {sel0, sel1}
  logic               busy_q;

  logic               hi_found, lo_found;
  logic [PTR_W-1:0]   hi_idx, lo_idx, win_idx, win_next;
  logic [N_REQ-1:0]   win_onehot;
  logic [1:0]         win_rate;
  logic               owner_req;

  // Round-robin pick: lowest asserted index at or above ptr, else lowest below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (PTR_W'(j) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(j);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
`ifdef LED_ARB_PRIO_EN
    if (req[0]) win_idx = '0;
`endif
    win_next = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    win_onehot = '0;
    win_rate   = 2'b00;
    for (int j = 0; j < N_REQ; j++) begin
      if (PTR_W'(j) == win_idx) begin
        win_onehot[j] = 1'b1;
        win_rate      = rate[2*j +: 2];
      end
    end
  end

  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    en_d    = en_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (hi_found || lo_found) begin
          state_d = StHold;
          grant_d = win_onehot;
          en_d    = 1'b1;
          sel_d   = win_rate;
          cnt_d   = '0;
          ptr_d   = win_next;
        end
      end
      StHold: begin
`ifdef LED_ARB_PRIO_EN
        if (req[0] && !grant_q[0]) begin
          grant_d    = '0;
          grant_d[0] = 1'b1;
          sel_d      = rate[1:0];
          cnt_d      = '0;
        end else
`endif
        if (!owner_req || cnt_q == HOLD_LAST) begin
          // Early release wins over a coincident final count, so no done then.
          if (owner_req) done_d = grant_q;
          grant_d = '0;
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
`ifdef LED_ARB_PRIO_EN
        if (req[0]) begin
          grant_d    = '0;
          grant_d[0] = 1'b1;
          en_d       = 1'b1;
          sel_d      = rate[1:0];
          cnt_d      = '0;
          state_d    = StHold;
        end else
`endif
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign led_enable = en_q;
  assign led_sel0   = sel_q[1];
  assign led_sel1   = sel_q[0];
  assign busy       = busy_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  enable_grant_a: assert property (@(posedge clk) disable iff (reset) led_enable == (|grant));

endmodule
